// File: rtl/sdio_init_pkg.sv
// Shared types and constants for the SD/SDIO card initialization sequencer.
// States CMD55W/ACMD6 exist only when SDIO_WIDEBUS_EN is defined.
package sdio_init_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CMD0   = 4'd1,
    S_CMD8   = 4'd2,
    S_CMD55A = 4'd3,
    S_ACMD41 = 4'd4,
    S_CMD2   = 4'd5,
    S_CMD3   = 4'd6,
    S_CMD7   = 4'd7,
`ifdef SDIO_WIDEBUS_EN
    S_CMD55W = 4'd8,
    S_ACMD6  = 4'd9,
`endif
    S_DONE   = 4'd10,
    S_ERR    = 4'd11
  } state_e;

  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_ALL_SEND_CID = 6'd2;
  localparam logic [5:0] CMD_SEND_RCA     = 6'd3;
  localparam logic [5:0] ACMD_SET_WIDTH   = 6'd6;
  localparam logic [5:0] CMD_SELECT       = 6'd7;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] ACMD_SEND_OP     = 6'd41;
  localparam logic [5:0] CMD_APP          = 6'd55;

  localparam logic [1:0] RSP_NONE  = 2'd0;
  localparam logic [1:0] RSP_SHORT = 2'd1;
  localparam logic [1:0] RSP_LONG  = 2'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ECHO  = 3'd1;
  localparam logic [2:0] ERR_RETRY = 3'd2;
  localparam logic [2:0] ERR_RSP   = 3'd3;
  localparam logic [2:0] ERR_RCA   = 3'd4;

  localparam logic [31:0] CMD8_ARG = 32'h0000_01a5;

endpackage

// File: rtl/sdio_init_seq.sv
// SD/SDIO card initialization sequencer: CMD0..CMD7, optional 4-bit bus switch.
// Define SDIO_WIDEBUS_EN to compile in the CMD55/ACMD6 bus-width stage.
module sdio_init_seq
  import sdio_init_pkg::*;
#(
  parameter logic        OPT_HIGH_CAPACITY = 1'b1,
  parameter int          RETRY_MAX         = 1000,
  parameter logic [15:0] OCR_VOLT          = 16'hff80
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [2:0]   o_err_code,
  output logic         o_cmd_valid,
  input  logic         i_cmd_ready,
  output logic [5:0]   o_cmd,
  output logic [31:0]  o_cmd_arg,
  output logic [1:0]   o_rsp_type,
  input  logic         i_rsp_valid,
  input  logic         i_rsp_err,
  input  logic [119:0] i_rsp_data,
  output logic [15:0]  o_rca,
  output logic         o_hcs,
  output logic [119:0] o_cid,
  output logic [1:0]   o_width
);

  localparam logic [15:0] RETRY_LIM = 16'(RETRY_MAX);

  state_e         state_q, state_d;
  logic           wait_q, wait_d;      // 0 = ISSUE phase, 1 = WAIT phase
  logic [15:0]    retry_q, retry_d;
  logic           hcs_req_q, hcs_req_d;
  logic           hcs_q, hcs_d;
  logic [15:0]    rca_q, rca_d;
  logic [119:0]   cid_q, cid_d;
  logic [2:0]     err_code_q, err_code_d;
  logic           cmd_live;
  logic [15:0]    retry_inc;

`ifdef SDIO_WIDEBUS_EN
  logic           width_q, width_d;
  assign o_width = {1'b0, width_q};
`else
  assign o_width = 2'b00;
`endif

  // Command fields decode purely from state, so they cannot move while valid is held.
  always_comb begin
    cmd_live   = 1'b1;
    o_cmd      = CMD_GO_IDLE;
    o_cmd_arg  = 32'h0;
    o_rsp_type = RSP_SHORT;
    case (state_q)
      S_CMD0:   o_rsp_type = RSP_NONE;
      S_CMD8:   begin o_cmd = CMD_SEND_IF_COND; o_cmd_arg = CMD8_ARG; end
      S_CMD55A: o_cmd = CMD_APP;
      S_ACMD41: begin
        o_cmd     = ACMD_SEND_OP;
        o_cmd_arg = {1'b0, hcs_req_q, 6'h0, OCR_VOLT, 8'h0};
      end
      S_CMD2:   begin o_cmd = CMD_ALL_SEND_CID; o_rsp_type = RSP_LONG; end
      S_CMD3:   o_cmd = CMD_SEND_RCA;
      S_CMD7:   begin o_cmd = CMD_SELECT; o_cmd_arg = {rca_q, 16'h0}; end
`ifdef SDIO_WIDEBUS_EN
      S_CMD55W: begin o_cmd = CMD_APP; o_cmd_arg = {rca_q, 16'h0}; end
      S_ACMD6:  begin o_cmd = ACMD_SET_WIDTH; o_cmd_arg = 32'h2; end
`endif
      default: begin
        cmd_live   = 1'b0;
        o_rsp_type = RSP_NONE;
      end
    endcase
  end

  assign o_cmd_valid = cmd_live & ~wait_q;
  assign retry_inc   = retry_q + 16'd1;

  // NOTE: every _d gets its _q value first, so no path through this block leaves a latch.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retry_d    = retry_q;
    hcs_req_d  = hcs_req_q;
    hcs_d      = hcs_q;
    rca_d      = rca_q;
    cid_d      = cid_q;
    err_code_d = err_code_q;
`ifdef SDIO_WIDEBUS_EN
    width_d    = width_q;
`endif
    if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
      if (i_start) begin
        state_d    = S_CMD0;
        wait_d     = 1'b0;
        retry_d    = 16'h0;
        hcs_req_d  = 1'b0;
        hcs_d      = 1'b0;
        rca_d      = 16'h0;
        err_code_d = ERR_NONE;
`ifdef SDIO_WIDEBUS_EN
        width_d    = 1'b0;
`endif
      end
    end else if (!wait_q) begin
      if (i_cmd_ready) begin
        if (state_q == S_CMD0) state_d = S_CMD8;
        else                   wait_d  = 1'b1;
      end
    end else if (i_rsp_valid) begin
      wait_d = 1'b0;
      // CMD8 is the only command where a failed reply is a legitimate answer.
      if (i_rsp_err && state_q != S_CMD8) begin
        state_d    = S_ERR;
        err_code_d = ERR_RSP;
      end else begin
        case (state_q)
          S_CMD8: begin
            if (i_rsp_err) begin
              hcs_req_d = 1'b0;
              state_d   = S_CMD55A;
            end else if (i_rsp_data[11:0] != CMD8_ARG[11:0]) begin
              state_d    = S_ERR;
              err_code_d = ERR_ECHO;
            end else begin
              hcs_req_d = OPT_HIGH_CAPACITY;
              state_d   = S_CMD55A;
            end
          end
          S_CMD55A: state_d = S_ACMD41;
          S_ACMD41: begin
            if (i_rsp_data[31]) begin
              hcs_d   = i_rsp_data[30] & hcs_req_q;
              state_d = S_CMD2;
            end else begin
              retry_d = retry_inc;
              if (retry_inc == RETRY_LIM) begin
                state_d    = S_ERR;
                err_code_d = ERR_RETRY;
              end else begin
                state_d = S_CMD55A;
              end
            end
          end
          S_CMD2: begin
            cid_d   = i_rsp_data;
            state_d = S_CMD3;
          end
          S_CMD3: begin
            rca_d = i_rsp_data[31:16];
            if (i_rsp_data[31:16] == 16'h0) begin
              state_d    = S_ERR;
              err_code_d = ERR_RCA;
            end else begin
              state_d = S_CMD7;
            end
          end
`ifdef SDIO_WIDEBUS_EN
          S_CMD7:   state_d = S_CMD55W;
          S_CMD55W: state_d = S_ACMD6;
          S_ACMD6: begin
            width_d = 1'b1;
            state_d = S_DONE;
          end
`else
          S_CMD7:   state_d = S_DONE;
`endif
          default:  state_d = state_q;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      wait_q     <= 1'b0;
      retry_q    <= 16'h0;
      hcs_req_q  <= 1'b0;
      hcs_q      <= 1'b0;
      rca_q      <= 16'h0;
      cid_q      <= '0;
      err_code_q <= ERR_NONE;
`ifdef SDIO_WIDEBUS_EN
      width_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retry_q    <= retry_d;
      hcs_req_q  <= hcs_req_d;
      hcs_q      <= hcs_d;
      rca_q      <= rca_d;
      cid_q      <= cid_d;
      err_code_q <= err_code_d;
`ifdef SDIO_WIDEBUS_EN
      width_q    <= width_d;
`endif
    end
  end

  assign o_busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign o_done     = (state_q == S_DONE);
  assign o_err      = (state_q == S_ERR);
  assign o_err_code = err_code_q;
  assign o_rca      = rca_q;
  assign o_hcs      = hcs_q;
  assign o_cid      = cid_q;

endmodule

// File: tb/tb_sdio_init_seq.sv
// Scoreboard bench for sdio_init_seq: expected commands are queued with their card
// replies; a monitor checks every handshake and a responder plays the card.
module tb_sdio_init_seq;

  logic         clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_start = 1'b0;
  logic         o_busy, o_done, o_err;
  logic [2:0]   o_err_code;
  logic         o_cmd_valid;
  logic         i_cmd_ready = 1'b1;
  logic [5:0]   o_cmd;
  logic [31:0]  o_cmd_arg;
  logic [1:0]   o_rsp_type;
  logic         i_rsp_valid = 1'b0;
  logic         i_rsp_err = 1'b0;
  logic [119:0] i_rsp_data = '0;
  logic [15:0]  o_rca;
  logic         o_hcs;
  logic [119:0] o_cid;
  logic [1:0]   o_width;

  always #5 clk = ~clk;

  sdio_init_seq #(
    .OPT_HIGH_CAPACITY(1'b1),
    .RETRY_MAX        (3),
    .OCR_VOLT         (16'hff80)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready),
    .o_cmd      (o_cmd),
    .o_cmd_arg  (o_cmd_arg),
    .o_rsp_type (o_rsp_type),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_err  (i_rsp_err),
    .i_rsp_data (i_rsp_data),
    .o_rca      (o_rca),
    .o_hcs      (o_hcs),
    .o_cid      (o_cid),
    .o_width    (o_width)
  );

  typedef struct { logic [5:0] cmd; logic [31:0] arg; logic [1:0] typ; } exp_t;
  typedef struct { bit has; bit err; logic [119:0] data; } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  exp_t mon_e;
  rsp_t drv_r;
  int   total = 0;
  int   bad = 0;
  int   stray_seq = 0;
  int   stray_seen = 0;

  localparam logic [119:0] CID_A = 120'h0123456789abcdef_fedcba98765432;
`ifdef SDIO_WIDEBUS_EN
  localparam logic [1:0] WIDTH_EXP = 2'd1;
`else
  localparam logic [1:0] WIDTH_EXP = 2'd0;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t,
                            input bit has, input bit err, input logic [119:0] d);
    exp_q.push_back('{cmd: c, arg: a, typ: t});
    rsp_q.push_back('{has: has, err: err, data: d});
  endtask

  task automatic start_seq();
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(o_done || o_err) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {127'h0, (o_done || o_err)}, 128'h1);
  endtask

  // Monitor: every accepted command must match the head of the expected queue.
  always @(negedge clk) begin
    if (i_reset_n && o_cmd_valid && i_cmd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got cmd %0d arg %0h want none", o_cmd, o_cmd_arg);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_idx", {122'h0, o_cmd}, {122'h0, mon_e.cmd});
        check("cmd_arg", {96'h0, o_cmd_arg}, {96'h0, mon_e.arg});
        check("rsp_type", {126'h0, o_rsp_type}, {126'h0, mon_e.typ});
      end
    end
  end

  // Card responder: reply three cycles after each handshake; also issues stray strobes on request.
  initial begin
    forever begin
      @(negedge clk);
      if (stray_seq != stray_seen) begin
        stray_seen = stray_seq;
        i_rsp_valid = 1'b1;
        i_rsp_err   = 1'b1;
        @(posedge clk);
        #1 i_rsp_valid = 1'b0;
        i_rsp_err = 1'b0;
      end else if (i_reset_n && o_cmd_valid && i_cmd_ready && rsp_q.size() != 0) begin
        drv_r = rsp_q.pop_front();
        if (drv_r.has) begin
          repeat (3) @(posedge clk);
          #1 i_rsp_valid = 1'b1;
          i_rsp_err  = drv_r.err;
          i_rsp_data = drv_r.data;
          @(posedge clk);
          #1 i_rsp_valid = 1'b0;
          i_rsp_err = 1'b0;
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", {127'h0, o_cmd_valid}, 128'h0);
    check("rst_flags", {125'h0, o_busy, o_done, o_err}, 128'h0);
    check("rst_err_code", {125'h0, o_err_code}, 128'h0);
    check("rst_cmd", {90'h0, o_cmd, o_cmd_arg}, 128'h0);
    check("rst_rca_hcs_w", {109'h0, o_rca, o_hcs, o_width}, 128'h0);
    check("rst_cid", {8'h0, o_cid}, 128'h0);
    @(negedge clk);
    i_reset_n = 1'b1;

    // Full init: echo OK, two busy ACMD41 replies, then ready with CCS
    expect_cmd(6'd0,  32'h0,        2'd0, 1'b0, 1'b0, '0);
    expect_cmd(6'd8,  32'h000001a5, 2'd1, 1'b1, 1'b0, 120'h1a5);
    expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
    expect_cmd(6'd41, 32'h40ff8000, 2'd1, 1'b1, 1'b0, 120'h00ff8000);
    expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
    expect_cmd(6'd41, 32'h40ff8000, 2'd1, 1'b1, 1'b0, 120'h00ff8000);
    expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
    expect_cmd(6'd41, 32'h40ff8000, 2'd1, 1'b1, 1'b0, 120'hc0ff8000);
    expect_cmd(6'd2,  32'h0,        2'd2, 1'b1, 1'b0, CID_A);
    expect_cmd(6'd3,  32'h0,        2'd1, 1'b1, 1'b0, 120'h12340500);
    expect_cmd(6'd7,  32'h12340000, 2'd1, 1'b1, 1'b0, 120'h700);
`ifdef SDIO_WIDEBUS_EN
    expect_cmd(6'd55, 32'h12340000, 2'd1, 1'b1, 1'b0, 120'h920);
    expect_cmd(6'd6,  32'h00000002, 2'd1, 1'b1, 1'b0, 120'h920);
`endif
    check("full_busy_at_start", 128'(o_busy), 128'h0);
    start_seq();
    check("full_busy", 128'(o_busy), 128'h1);
    wait_end("full_timeout");
    check("full_done_err", {126'h0, o_done, o_err}, 128'h2);
    check("full_hcs", 128'(o_hcs), 128'h1);
    check("full_rca", 128'(o_rca), 128'h1234);
    check("full_width", 128'(o_width), 128'(WIDTH_EXP));
    check("full_cid", {8'h0, o_cid}, {8'h0, CID_A});
    check("full_queue_empty", 128'(exp_q.size()), 128'h0);

    // Stray reply strobe while DONE must be ignored
    stray_seq++;
    repeat (6) @(negedge clk);
    check("stray_done", {125'h0, o_done, o_err, o_busy}, 128'h4);

    // Legacy card: CMD8 times out, CCS in the ACMD41 reply must not set o_hcs
    expect_cmd(6'd0,  32'h0,        2'd0, 1'b0, 1'b0, '0);
    expect_cmd(6'd8,  32'h000001a5, 2'd1, 1'b1, 1'b1, '0);
    expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
    expect_cmd(6'd41, 32'h00ff8000, 2'd1, 1'b1, 1'b0, 120'hc0ff8000);
    expect_cmd(6'd2,  32'h0,        2'd2, 1'b1, 1'b0, 120'h5a);
    expect_cmd(6'd3,  32'h0,        2'd1, 1'b1, 1'b0, 120'habcd0000);
    expect_cmd(6'd7,  32'h0,        2'd1, 1'b1, 1'b0, 120'h700);
    exp_q[6].arg = 32'habcd0000;
`ifdef SDIO_WIDEBUS_EN
    expect_cmd(6'd55, 32'habcd0000, 2'd1, 1'b1, 1'b0, 120'h920);
    expect_cmd(6'd6,  32'h00000002, 2'd1, 1'b1, 1'b0, 120'h920);
`endif
    start_seq();
    check("legacy_width_cleared", 128'(o_width), 128'h0);
    wait_end("legacy_timeout");
    check("legacy_done", 128'(o_done), 128'h1);
    check("legacy_hcs", 128'(o_hcs), 128'h0);
    check("legacy_rca", 128'(o_rca), 128'habcd);
    check("legacy_queue_empty", 128'(exp_q.size()), 128'h0);

    // Retries exhausted: RETRY_MAX=3, card stays busy
    expect_cmd(6'd0,  32'h0,        2'd0, 1'b0, 1'b0, '0);
    expect_cmd(6'd8,  32'h000001a5, 2'd1, 1'b1, 1'b0, 120'h1a5);
    for (int k = 0; k < 3; k++) begin
      expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
      expect_cmd(6'd41, 32'h40ff8000, 2'd1, 1'b1, 1'b0, 120'h00ff8000);
    end
    start_seq();
    wait_end("retry_timeout");
    repeat (10) @(negedge clk);
    check("retry_err", {126'h0, o_err, o_done}, 128'h2);
    check("retry_code", 128'(o_err_code), 128'h2);
    check("retry_queue_empty", 128'(exp_q.size()), 128'h0);

    // Zero RCA -> error 4
    expect_cmd(6'd0,  32'h0,        2'd0, 1'b0, 1'b0, '0);
    expect_cmd(6'd8,  32'h000001a5, 2'd1, 1'b1, 1'b0, 120'h1a5);
    expect_cmd(6'd55, 32'h0,        2'd1, 1'b1, 1'b0, 120'h120);
    expect_cmd(6'd41, 32'h40ff8000, 2'd1, 1'b1, 1'b0, 120'hc0ff8000);
    expect_cmd(6'd2,  32'h0,        2'd2, 1'b1, 1'b0, 120'h77);
    expect_cmd(6'd3,  32'h0,        2'd1, 1'b1, 1'b0, 120'h0);
    start_seq();
    check("rca0_retry_cleared_busy", 128'(o_err), 128'h0);
    wait_end("rca0_timeout");
    check("rca0_err", 128'(o_err), 128'h1);
    check("rca0_code", 128'(o_err_code), 128'h4);
    check("rca0_hcs_before", 128'(o_hcs), 128'h1);

    // Restart from ERR with the engine stalled: outputs cleared, CMD0 presented
    i_cmd_ready = 1'b0;
    expect_cmd(6'd0, 32'h0, 2'd0, 1'b0, 1'b0, '0);
    start_seq();
    check("restart_code", 128'(o_err_code), 128'h0);
    check("restart_hcs_rca_w", {109'h0, o_rca, o_hcs, o_width}, 128'h0);
    check("restart_flags", {124'h0, o_busy, o_done, o_err, o_cmd_valid}, 128'h9);
    check("restart_cmd", {90'h0, o_cmd, o_cmd_arg}, 128'h0);
    i_cmd_ready = 1'b1;
    @(posedge clk);
    #1 i_cmd_ready = 1'b0;

    // CMD8 held 10 cycles without ready; asynchronous reset at cycle 5
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        #2 i_reset_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(o_cmd_valid), 128'h0);
        check("async_rst_idle", {126'h0, o_busy, o_done}, 128'h0);
        check("async_rst_cmd", {90'h0, o_cmd, o_cmd_arg}, 128'h0);
      end else if (i < 5) begin
        check("stall_valid", 128'(o_cmd_valid), 128'h1);
        check("stall_cmd", {90'h0, o_cmd, o_cmd_arg}, {90'h0, 6'd8, 32'h000001a5});
      end else begin
        check("held_rst_idle", {126'h0, o_busy, o_cmd_valid}, 128'h0);
      end
    end
    @(negedge clk);
    i_reset_n = 1'b1;
    i_cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {124'h0, o_busy, o_done, o_err, o_cmd_valid}, 128'h0);
    check("post_rst_code", 128'(o_err_code), 128'h0);
    check("final_queue_empty", 128'(exp_q.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sdio_init_seq.md
SDIO_INIT_SEQ -- requirements
Module: sdio_init_seq

Interface
REQ-001 SHALL have parameter OPT_HIGH_CAPACITY, default 1'b1: request HCS in ACMD41 and honour CCS.
REQ-002 SHALL have parameter RETRY_MAX, default 1000: maximum ACMD41 attempts, 16-bit counter.
REQ-003 SHALL have parameter OCR_VOLT, default 16'hff80: voltage window placed in ACMD41 arg[23:8].
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
  i_clk  in  1  single clock; all state on rising edge.
  i_reset_n  in  1  reset, asynchronous, active-low.
  i_start  in  1  begin initialization; ignored while o_busy.
  o_busy / o_done / o_err  out  1 each  sequence running / completed OK / failed.
  o_err_code  out  3  1=CMD8 echo bad, 2=ACMD41 retries exhausted, 3=response error, 4=RCA zero.
  o_cmd_valid  out  1  command request, held until i_cmd_ready.
  i_cmd_ready  in  1  command engine accepts.
  o_cmd  out  6  command index.
  o_cmd_arg  out  32  command argument.
  o_rsp_type  out  2  expected reply: 0 none, 1 R1/R3/R6/R7 (48b), 2 R2 (136b).
  i_rsp_valid  in  1  one-cycle reply strobe.
  i_rsp_err  in  1  qualifies i_rsp_valid: timeout or CRC fail.
  i_rsp_data  in  120  reply payload; short replies in [31:0].
  o_rca  out  16  card RCA.  o_hcs  out  1  card is high capacity.
  o_cid  out  120  CID captured from CMD2.  o_width  out  2  bus width: 0=1b, 1=4b.

Function
REQ-005 SHALL implement states IDLE, CMD0, CMD8, CMD55A, ACMD41, CMD2, CMD3, CMD7, CMD55W, ACMD6, DONE, ERR; each command state has an ISSUE phase (o_cmd_valid=1) and a WAIT phase.
REQ-006 SHALL hold o_cmd, o_cmd_arg, o_rsp_type stable while o_cmd_valid=1 and not ready; o_cmd_valid drops the cycle after handshake.
REQ-007 CMD0: arg 0, type 0; SHALL advance to CMD8 on handshake, with no wait for a reply.
REQ-008 CMD8: arg 32'h0000_01a5; reply with i_rsp_err=1 -> legacy card, hcs_req=0, go CMD55A; reply [11:0]!=12'h1a5 -> ERR code 1; else hcs_req=OPT_HIGH_CAPACITY.
REQ-009 CMD55A: arg 0; ACMD41: arg {1'b0,hcs_req,6'h0,OCR_VOLT,8'h0}, type 1 (no CRC check expected of engine).
REQ-010 ACMD41 reply [31]=0 SHALL increment the retry count and return to CMD55A; if the count reaches RETRY_MAX, go ERR code 2; [31]=1 -> o_hcs<=[30]&hcs_req, go CMD2.
REQ-011 CMD2: arg 0, type 2; SHALL latch o_cid<=i_rsp_data.
REQ-012 CMD3: arg 0; SHALL latch o_rca<=[31:16]; a zero RCA -> ERR code 4.
REQ-013 CMD7: arg {o_rca,16'h0}; success -> CMD55W (SDIO_WIDEBUS_EN) or DONE.
REQ-014 CMD55W: arg {o_rca,16'h0}; ACMD6: arg 32'h2; success -> o_width<=1, DONE.
REQ-015 i_rsp_err=1 in any WAIT phase other than CMD8 SHALL go to ERR code 3.
REQ-016 i_rsp_valid outside a WAIT phase SHALL be ignored.
REQ-017 o_busy=1 in all states except IDLE, DONE, ERR; o_done=1 only in DONE; o_err=1 only in ERR.
REQ-018 i_start in DONE/ERR SHALL restart at CMD0, clearing o_err_code, o_width, o_hcs, o_rca, and the retry count on the same edge.

Reset
REQ-019 i_reset_n=0 SHALL force IDLE immediately: o_cmd_valid=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_cmd=0, o_cmd_arg=0, o_rsp_type=0, o_rca=0, o_hcs=0, o_cid=0, o_width=0, retry count 0.
REQ-020 A reset asserted mid-handshake SHALL abandon the command; no state is retained.

Configuration
REQ-021 Macro SDIO_WIDEBUS_EN defined: CMD55W/ACMD6 are compiled in and DONE implies o_width=1. Undefined: those states are absent, CMD7 goes to DONE, and o_width is constant 0.

Structure
REQ-022 Package sdio_init_pkg SHALL hold the state enum, command index constants (0,2,3,6,7,8,41,55), rsp-type encodings and error codes.
REQ-023 SHALL contain no sub-module; the retry counter and phase flag are inline.

Verification
REQ-024 Full init: CMD8 echo 1a5, ACMD41 [31]=0 twice then 32'hc0ff8000, RCA 16'h1234 -> commands 0,8,55,41,55,41,55,41,2,3,7,55,6; o_hcs=1, o_rca=1234, o_width=1, o_done=1.
REQ-025 CMD8 i_rsp_err=1 -> ACMD41 arg 32'h00ff8000; o_hcs=0 even if the reply [30]=1.
REQ-026 RETRY_MAX=3, ACMD41 always busy -> exactly 3 ACMD41 issued, then o_err=1, code 2.
REQ-027 CMD3 reply 32'h0 -> ERR code 4; next i_start -> CMD0 reissued with outputs cleared.
REQ-028 i_cmd_ready held low 10 cycles -> o_cmd/o_cmd_arg stable throughout; reset pulse at cycle 5 -> o_cmd_valid=0 asynchronously, state IDLE.
